// File: rtl/iram_access_ctrl.sv
// Arbitrated sequencer in front of the 8051 internal RAM/SFR array.
// Serves ports A and B round-robin and turns bit accesses into byte read or read-modify-write sequences.
module iram_access_ctrl #(
    parameter int                       ADDRESS_WIDTH = 8,
    parameter logic [ADDRESS_WIDTH-1:0] BIT_BASE      = 8'h20
) (
    input  logic                     clock,
    input  logic                     reset,

    // Handshake: a port raises req with its fields stable and holds them until
    // its ack pulses for one cycle; req is dropped at the edge ending that cycle.
    // A req still high in IDLE is a new request.
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic                     a_is_bit,
    input  logic                     a_ind,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [7:0]               a_wdata,
    input  logic                     a_wbit,
    output logic                     a_ack,

    input  logic                     b_req,
    input  logic                     b_we,
    input  logic                     b_is_bit,
    input  logic                     b_ind,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic [7:0]               b_wdata,
    input  logic                     b_wbit,
    output logic                     b_ack,

    output logic [7:0]               rdata,
    output logic                     rbit,
    output logic                     busy,

    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_rd,
    output logic                     ram_wr,
    output logic                     ram_ind,
    output logic [7:0]               ram_wdata,
    input  logic [7:0]               ram_rdata,

    output logic [2:0]               dbg_state
);

    localparam int AW = ADDRESS_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_ACK  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic          we_q;
    logic          is_bit_q;
    logic          ind_q;
    logic          wbit_q;
    logic          grant_b_q;
    logic          last_b_q;
    logic [2:0]    bit_q;
    logic [7:0]    data_q;
    logic [AW-1:0] addr_q;
    logic [7:0]    rdata_q;
    logic          rbit_q;

    logic          any_req;
    logic          pick_b;
    logic          sel_we;
    logic          sel_is_bit;
    logic          sel_ind;
    logic          sel_wbit;
    logic [AW-1:0] sel_addr;
    logic [AW-1:0] sel_byte;
    logic [7:0]    sel_wdata;
    logic [7:0]    rmw_byte;

    // B wins only when alone or when A was served last.
    always_comb begin
        any_req    = a_req | b_req;
        pick_b     = b_req & (~a_req | ~last_b_q);
        sel_we     = pick_b ? b_we     : a_we;
        sel_is_bit = pick_b ? b_is_bit : a_is_bit;
        sel_ind    = pick_b ? b_ind    : a_ind;
        sel_wbit   = pick_b ? b_wbit   : a_wbit;
        sel_addr   = pick_b ? b_addr   : a_addr;
        sel_wdata  = pick_b ? b_wdata  : a_wdata;
    end

    // Low bit space packs 8 bits per byte from BIT_BASE; high bit space maps to SFRs at x0h/x8h.
    always_comb begin
        sel_byte = sel_addr;
        if (sel_is_bit) begin
            if (sel_addr < AW'(8'h80)) begin
                sel_byte = BIT_BASE + AW'(sel_addr[6:3]);
            end else begin
                sel_byte = {sel_addr[AW-1:3], 3'b000};
            end
        end
    end

    always_comb begin
        rmw_byte         = ram_rdata;
        rmw_byte[bit_q]  = wbit_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (any_req) begin
                    state_nx = (sel_we && !sel_is_bit) ? S_WR : S_RD;
                end
            end
            S_RD:    state_nx = S_CAP;
            S_CAP:   state_nx = (we_q && is_bit_q) ? S_WR : S_ACK;
            S_WR:    state_nx = S_ACK;
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_q      <= 1'b0;
            is_bit_q  <= 1'b0;
            ind_q     <= 1'b0;
            wbit_q    <= 1'b0;
            grant_b_q <= 1'b0;
            last_b_q  <= 1'b1;
            bit_q     <= 3'd0;
            data_q    <= 8'h00;
            addr_q    <= '0;
            rdata_q   <= 8'h00;
            rbit_q    <= 1'b0;
        end else begin
            if (state == S_IDLE && any_req) begin
                we_q      <= sel_we;
                is_bit_q  <= sel_is_bit;
                ind_q     <= sel_ind & ~sel_is_bit;
                wbit_q    <= sel_wbit;
                grant_b_q <= pick_b;
                last_b_q  <= pick_b;
                bit_q     <= sel_addr[2:0];
                data_q    <= sel_wdata;
                addr_q    <= sel_byte;
            end
            // A bit write reuses data_q as the hold byte and leaves the read results alone.
            if (state == S_CAP) begin
                if (we_q) begin
                    data_q <= rmw_byte;
                end else begin
                    rdata_q <= ram_rdata;
                    rbit_q  <= ram_rdata[bit_q];
                end
            end
        end
    end

    always_comb begin
        ram_rd    = (state == S_RD);
        ram_wr    = (state == S_WR);
        ram_ind   = (ram_rd | ram_wr) & ind_q;
        ram_wdata = ram_wr ? data_q : 8'h00;
        ram_addr  = addr_q;
        a_ack     = (state == S_ACK) & ~grant_b_q;
        b_ack     = (state == S_ACK) & grant_b_q;
        busy      = (state != S_IDLE);
        rdata     = rdata_q;
        rbit      = rbit_q;
        dbg_state = state;
    end

endmodule

// File: tb/tb_iram_access_ctrl.sv
// Bench for iram_access_ctrl: a behavioural RAM, directed scenarios and random two-port traffic,
// all checked cycle by cycle against a transaction-level model of the controller.
module tb_iram_access_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       a_req, a_we, a_is_bit, a_ind, a_wbit, a_ack;
    logic [7:0] a_addr, a_wdata;
    logic       b_req, b_we, b_is_bit, b_ind, b_wbit, b_ack;
    logic [7:0] b_addr, b_wdata;
    logic [7:0] rdata;
    logic       rbit, busy;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_rd, ram_wr, ram_ind;
    logic [2:0] dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    iram_access_ctrl #(.ADDRESS_WIDTH(8), .BIT_BASE(8'h20)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_is_bit(a_is_bit), .a_ind(a_ind),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_wbit(a_wbit), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_is_bit(b_is_bit), .b_ind(b_ind),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_wbit(b_wbit), .b_ack(b_ack),
        .rdata(rdata), .rbit(rbit), .busy(busy),
        .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_ind(ram_ind),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM: registered read, write at end of cycle ----------------
    logic [7:0] ram_mem [256];
    always @(posedge clock) begin
        if (ram_rd) ram_rdata <= ram_mem[ram_addr];
        if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
    end

    // ---------------- check helpers ----------------
    task automatic check1(input string name, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0b required %0b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %02h required %02h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // One expected record per busy cycle of the transaction in flight.
    typedef struct packed {
        logic       rd, wr, ind, a_ack, b_ack, commit, upd, rbv, rbk;
        logic [7:0] addr, wdata, rdv;
    } rec_t;

    rec_t       exp_q[$];
    logic [7:0] model_mem [256];
    logic       m_last_b;
    logic [7:0] m_rdata;
    logic       m_rbit;
    logic       m_rbk;
    logic [7:0] m_last_addr;

    task automatic predict();
        logic       gb, we, isb, ind, wbit, ie;
        logic [7:0] ad, wd, r, mem, modv;
        int         bpos;
        rec_t       t;
        gb       = b_req && (!a_req || !m_last_b);
        m_last_b = gb;
        we   = gb ? b_we     : a_we;
        isb  = gb ? b_is_bit : a_is_bit;
        ind  = gb ? b_ind    : a_ind;
        wbit = gb ? b_wbit   : a_wbit;
        ad   = gb ? b_addr   : a_addr;
        wd   = gb ? b_wdata  : a_wdata;
        bpos = int'(ad) % 8;
        if (!isb)            r = ad;
        else if (ad < 8'h80) r = 8'h20 + ad / 8;
        else                 r = ad - 8'(bpos);
        ie          = isb ? 1'b0 : ind;
        mem         = model_mem[r];
        m_last_addr = r;

        t = '0; t.addr = r;
        if (we && !isb) begin
            t.wr = 1; t.ind = ie; t.wdata = wd; t.commit = 1;
            exp_q.push_back(t);
        end else begin
            t.rd = 1; t.ind = ie;
            exp_q.push_back(t);
            t = '0; t.addr = r;
            exp_q.push_back(t);
            if (we) begin
                modv       = mem;
                modv[bpos] = wbit;
                t.wr = 1; t.ind = 0; t.wdata = modv; t.commit = 1;
                exp_q.push_back(t);
            end
        end
        t = '0; t.addr = r; t.a_ack = !gb; t.b_ack = gb;
        if (!we) begin
            t.upd = 1; t.rdv = mem; t.rbv = mem[bpos]; t.rbk = isb;
        end
        exp_q.push_back(t);
    endtask

    task automatic model_loop();
        rec_t cur;
        bit   was_idle;
        forever begin
            @(negedge clock);
            if (reset) begin
                exp_q.delete();
                m_last_b    = 1'b1;
                m_rdata     = 8'h00;
                m_rbit      = 1'b0;
                m_rbk       = 1'b1;
                m_last_addr = 8'h00;
                was_idle    = 1'b1;
            end else begin
                was_idle = (exp_q.size() == 0);
            end
            cur = '0;
            cur.addr = m_last_addr;
            if (!was_idle) cur = exp_q.pop_front();
            if (cur.commit) model_mem[cur.addr] = cur.wdata;
            if (cur.upd) begin
                m_rdata = cur.rdv;
                m_rbit  = cur.rbv;
                m_rbk   = cur.rbk;
            end
            check1("a_ack", a_ack, cur.a_ack);
            check1("b_ack", b_ack, cur.b_ack);
            check1("busy", busy, !was_idle);
            check1("dbg_state_idle", dbg_state == 3'd0, was_idle);
            check1("ram_rd", ram_rd, cur.rd);
            check1("ram_wr", ram_wr, cur.wr);
            check1("ram_ind", ram_ind, cur.ind);
            check8("ram_wdata", ram_wdata, cur.wdata);
            check8("ram_addr", ram_addr, cur.addr);
            check8("rdata", rdata, m_rdata);
            if (m_rbk) check1("rbit", rbit, m_rbit);
            if (!reset && was_idle && (a_req || b_req)) predict();
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic access_a(input logic we, input logic is_bit, input logic ind,
                            input logic [7:0] addr, input logic [7:0] wdata, input logic wbit,
                            output int lat, output logic seen_ind);
        bit got;
        @(posedge clock); #1;
        a_we = we; a_is_bit = is_bit; a_ind = ind; a_addr = addr; a_wdata = wdata; a_wbit = wbit;
        a_req = 1'b1;
        got = 0; lat = 0; seen_ind = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            lat++;
            if ((ram_rd || ram_wr) && ram_ind) seen_ind = 1;
            if (a_ack) got = 1;
        end
        lat = lat - 1;
        check1("a_ack_arrived", got, 1'b1);
        @(posedge clock); #1;
        a_req = 1'b0;
    endtask

    task automatic access_b(input logic we, input logic is_bit, input logic ind,
                            input logic [7:0] addr, input logic [7:0] wdata, input logic wbit,
                            output int lat, output logic seen_ind);
        bit got;
        @(posedge clock); #1;
        b_we = we; b_is_bit = is_bit; b_ind = ind; b_addr = addr; b_wdata = wdata; b_wbit = wbit;
        b_req = 1'b1;
        got = 0; lat = 0; seen_ind = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            lat++;
            if ((ram_rd || ram_wr) && ram_ind) seen_ind = 1;
            if (b_ack) got = 1;
        end
        lat = lat - 1;
        check1("b_ack_arrived", got, 1'b1);
        @(posedge clock); #1;
        b_req = 1'b0;
    endtask

    task automatic agent_a(input int n);
        int   lat;
        logic si;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            access_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     lat, si);
        end
    endtask

    task automatic agent_b(input int n);
        int   lat;
        logic si;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) @(posedge clock);
            access_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     lat, si);
        end
    endtask

    // Both ports request byte reads together; each keeps req high until it has its quota of acks.
    int tie_order[$];
    task automatic tie_run(input int need_a, input int need_b);
        int na, nb;
        bit da, db;
        na = 0; nb = 0;
        tie_order.delete();
        @(posedge clock); #1;
        a_we = 0; a_is_bit = 0; a_ind = 0; a_addr = 8'($urandom_range(0, 255)); a_req = 1'b1;
        b_we = 0; b_is_bit = 0; b_ind = 0; b_addr = 8'($urandom_range(0, 255)); b_req = 1'b1;
        for (int c = 0; c < 80 && (na < need_a || nb < need_b); c++) begin
            @(negedge clock);
            da = 0; db = 0;
            if (a_ack) begin na++; tie_order.push_back(0); da = (na >= need_a); end
            if (b_ack) begin nb++; tie_order.push_back(1); db = (nb >= need_b); end
            @(posedge clock); #1;
            if (da) a_req = 1'b0;
            if (db) b_req = 1'b0;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check_int("tie_ack_count", na + nb, need_a + need_b);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int   lat;
        logic si;
        bit   ack_seen;

        reset = 1'b1;
        a_req = 0; a_we = 0; a_is_bit = 0; a_ind = 0; a_addr = 0; a_wdata = 0; a_wbit = 0;
        b_req = 0; b_we = 0; b_is_bit = 0; b_ind = 0; b_addr = 0; b_wdata = 0; b_wbit = 0;
        fork
            model_loop();
        join_none
        repeat (3) @(negedge clock);
        check1("reset_busy", busy, 1'b0);
        check8("reset_rdata", rdata, 8'h00);
        check8("reset_ram_addr", ram_addr, 8'h00);
        #1 reset = 1'b0;

        // Fill the whole RAM so every later read has a known value.
        for (int i = 0; i < 256; i++) begin
            access_a(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'(i), 8'($urandom_range(0, 255)), 1'b0, lat, si);
        end

        // Byte write then read back.
        access_a(1'b1, 1'b0, 1'b0, 8'h30, 8'h5A, 1'b0, lat, si);
        check_int("byte_write_latency", lat, 2);
        check8("byte_write_ram30", ram_mem[8'h30], 8'h5A);
        access_a(1'b0, 1'b0, 1'b0, 8'h30, 8'h00, 1'b0, lat, si);
        check_int("byte_read_latency", lat, 3);
        check8("byte_read_rdata", rdata, 8'h5A);

        // Low-area bit write: bit 13h lives in 22h bit 3.
        access_a(1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 1'b0, lat, si);
        access_b(1'b1, 1'b1, 1'b0, 8'h13, 8'h00, 1'b1, lat, si);
        check_int("bit_write_latency", lat, 4);
        check8("bit_write_ram22", ram_mem[8'h22], 8'h08);

        // SFR bit read: D7h is PSW.7, ind requested but ignored for bit accesses.
        access_a(1'b1, 1'b0, 1'b0, 8'hD0, 8'h80, 1'b0, lat, si);
        access_a(1'b0, 1'b1, 1'b1, 8'hD7, 8'h00, 1'b0, lat, si);
        check_int("bit_read_latency", lat, 3);
        check1("sfr_rbit", rbit, 1'b1);
        check8("sfr_rdata", rdata, 8'h80);
        check8("sfr_ram_addr", ram_addr, 8'hD0);
        check1("sfr_ram_ind", si, 1'b0);

        // Indirect vs direct upper access.
        access_a(1'b0, 1'b0, 1'b1, 8'h90, 8'h00, 1'b0, lat, si);
        check1("ind_read_ram_ind", si, 1'b1);
        access_a(1'b0, 1'b0, 1'b0, 8'h90, 8'h00, 1'b0, lat, si);
        check1("direct_read_ram_ind", si, 1'b0);

        // Tie arbitration: alternation starting with A (last grant was A, so reset B first).
        access_b(1'b0, 1'b0, 1'b0, 8'h10, 8'h00, 1'b0, lat, si);
        tie_run(2, 2);
        for (int i = 0; i < 4; i++) begin
            check_int("tie_order", (tie_order.size() > i) ? tie_order[i] : 9, i % 2);
        end

        // Random concurrent traffic.
        fork
            agent_a(60);
            agent_b(60);
        join

        // Reset during the CAP cycle of a bit write to 20h.0.
        access_a(1'b1, 1'b0, 1'b0, 8'h20, 8'hA4, 1'b0, lat, si);
        @(posedge clock); #1;
        a_we = 1; a_is_bit = 1; a_ind = 0; a_addr = 8'h00; a_wdata = 8'h00; a_wbit = 1; a_req = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check1("abort_busy", busy, 1'b0);
        check1("abort_ram_rd", ram_rd, 1'b0);
        check1("abort_ram_wr", ram_wr, 1'b0);
        check1("abort_a_ack", a_ack, 1'b0);
        check8("abort_ram_addr", ram_addr, 8'h00);
        check8("abort_rdata", rdata, 8'h00);
        a_req = 1'b0;
        ack_seen = 0;
        repeat (2) begin
            @(negedge clock);
            if (a_ack) ack_seen = 1;
        end
        #1 reset = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (a_ack) ack_seen = 1;
        end
        check1("abort_no_ack", ack_seen, 1'b0);
        check8("abort_ram20_kept", ram_mem[8'h20], 8'hA4);
        access_a(1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 1'b0, lat, si);
        check8("abort_readback", rdata, 8'hA4);
        // The readback left A as last grant; a fresh reset must hand the next tie to A.
        @(posedge clock); #1 reset = 1'b1;
        @(negedge clock); #1 reset = 1'b0;
        tie_run(1, 1);
        check_int("post_reset_first_grant", (tie_order.size() > 0) ? tie_order[0] : 9, 0);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/iram_access_ctrl.md
# iram_access_ctrl

Sequencing and arbitration controller in front of the 8051 single-port internal data RAM/SFR array (256 bytes, direct, indirect and bit-addressable regions). It shares the RAM between two requesters, port A (core execute unit) and port B (interrupt/stack unit), using round-robin arbitration. It converts bit accesses into byte read or read-modify-write sequences using 8051 bit-address decoding. The RAM it drives has a registered read (data valid the cycle after `ram_rd`) and a write that commits on the clock edge at the end of the `ram_wr` cycle.

## Interface
- `ADDRESS_WIDTH`, 8, byte address width of the RAM.
- `BIT_BASE`, 8'h20, first byte of the low bit-addressable area (20h–2Fh).
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `a_req`, `b_req` in 1: access request; held until ack.
- `a_we`, `b_we` in 1: 1 = write, 0 = read.
- `a_is_bit`, `b_is_bit` in 1: 1 = bit access, 0 = byte access.
- `a_ind`, `b_ind` in 1: indirect byte access (selects upper IRAM, not SFR, for addr ≥ 80h).
- `a_addr`, `b_addr` in ADDRESS_WIDTH: byte address, or bit address when is_bit = 1.
- `a_wdata`, `b_wdata` in 8: byte write data.
- `a_wbit`, `b_wbit` in 1: bit write value.
- `a_ack`, `b_ack` out 1: one-cycle completion pulse.
- `rdata` out 8: byte read result, or the full source byte for a bit read.
- `rbit` out 1: bit read result.
- `busy` out 1: high when state ≠ IDLE.
- `ram_addr` out ADDRESS_WIDTH, `ram_rd` out 1, `ram_wr` out 1, `ram_ind` out 1, `ram_wdata` out 8: RAM-side command.
- `ram_rdata` in 8: RAM read data, valid the cycle after `ram_rd`.

## Operation
- **States:** IDLE, RD, CAP, WR, ACK.
- **IDLE:** samples `a_req`/`b_req`.
  - If a request is present, latches the granted requester's we, is_bit, ind, addr, wdata and wbit, and records the grant.
  - Byte write goes to WR; every other access goes to RD.
- **Arbitration:** a single request is granted. If both are present, the port not granted last wins. `last_grant` resets to B, so A wins the first tie.
- **Bit decode:**
  - Bit address < 80h: byte = `BIT_BASE` + addr[6:3], bit = addr[2:0].
  - Bit address ≥ 80h: byte = {addr[7:3], 3'b000} (SFRs ending in 0h/8h), bit = addr[2:0].
  - Bit accesses force `ram_ind` = 0.
- **RD:** drives `ram_rd` = 1 and `ram_addr` = the resolved byte. Next state is CAP.
- **CAP:** `ram_rdata` is registered into `rdata`; `rbit` is registered as the selected bit.
  - Bit write: next state is WR, with the hold byte = `ram_rdata` and the selected bit replaced by wbit.
  - Otherwise: next state is ACK.
- **WR:** drives `ram_wr` = 1 for one cycle, with `ram_wdata` = wdata (byte write) or the modified hold byte (bit write). Next state is ACK.
- **ACK:** the granted port's ack = 1; `busy` stays 1. Next state is IDLE.
- **Output values:**
  - `ram_rd` and `ram_wr` are never high together.
  - `ram_*` outputs are 0 outside RD/WR, except `ram_addr`, which holds its last value.
  - `rdata`/`rbit` hold until the next read completes; writes do not change them.
- **Requester rule:** the port keeps req and its fields stable until ack and drops req at the edge that ends the ack cycle. If req is still high in IDLE, that is a new request.

## Timing
- Latency is counted from the IDLE sampling edge E0 to the ack cycle:
  - byte write: ack in cycle E0+2;
  - byte read: ack in cycle E0+3;
  - bit read: ack in cycle E0+3;
  - bit write (RMW): ack in cycle E0+4.
- Throughput: one access in flight. The next grant is sampled on the edge leaving ACK+IDLE; there are no back-to-back transactions without an IDLE cycle.
- **Reset values:** state IDLE, `last_grant` B, all outputs 0 (`a_ack`, `b_ack`, `rdata`, `rbit`, `busy`, `ram_*`).
- **Reset mid-transaction:** the transaction is aborted with no ack. A bit write aborted before WR leaves the RAM byte unchanged. `ram_wr` drops immediately (asynchronous).
- **Simultaneous events:** a request arriving while busy waits, and the losing port waits. Neither is dropped.

## Test plan
- **Byte write then read:** A writes 8'h5A to 30h, then reads 30h → `ram_wr` pulse with addr 30h/data 5Ah, `a_ack` at E0+2; the read gives `rdata` = 5Ah and `a_ack` at E0+3.
- **Low-area bit write:** RAM[22h] = 8'h00; B bit-writes bit address 13h to 1 → `ram_rd` addr 22h, then `ram_wr` addr 22h data 08h, `b_ack` at E0+4.
- **SFR bit read:** RAM[D0h] = 8'h80; A bit-reads D7h → `ram_addr` = D0h, `rbit` = 1, `rdata` = 80h, `ram_ind` = 0.
- **Tie arbitration:** A and B request in the same cycle, repeatedly, for 4 transactions → grant order A, B, A, B; each ack pulses exactly once.
- **Indirect access:** A byte-reads 90h with ind = 1 → `ram_ind` = 1 during RD; the same access with ind = 0 → `ram_ind` = 0.
- **Reset during RMW:** reset asserted in the CAP cycle of a bit write to 20h.0 → all outputs 0 immediately, no ack, RAM[20h] unchanged; after release, A's first tie-break win is restored.
